// File: rtl/usb_wb_bridge.sv
// rtl/usb_wb_bridge.sv - USB ch1 command packets to single Wishbone accesses with response packets
// Optional feature macro: USB_WB_BRIDGE_TIMEOUT_EN (Wishbone no-response timeout).
package usb_wb_pkg;
  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
    logic        cyc;
    logic        stb;
  } wb_m2s_t;

  typedef struct packed {
    logic [31:0] dat;
    logic        ack;
    logic        err;
  } wb_s2m_t;
endpackage

module usb_wb_bridge
  import usb_wb_pkg::*;
#(
  parameter int CHANNEL_ID     = 1,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  input  logic [31:0] rx_data_i,
  input  logic        rx_last_i,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic [31:0] tx_data_o,
  output logic [7:0]  tx_dst_o,
  output logic [31:0] tx_length_o,
  output logic        tx_last_o,
  output wb_m2s_t     wb_m2s_o,
  input  wb_s2m_t     wb_s2m_i,
  output logic        busy_o
);
  typedef enum logic [3:0] {
    IDLE, ADDR, WR_DATA, WB_WR, WR_DRAIN, RD_DRAIN, RD_WB, RD_TX, STATUS
  } state_t;

  state_t      state;
  logic [3:0]  op;
  logic [7:0]  n, cnt, done;
  logic [31:0] addr;
  logic        last_seen, malformed, wberr, tmo, live;
  logic        tmo_hit, rx_fire, tx_fire, wb_fail, wb_ok;

  function automatic wb_m2s_t wb_req(input logic [31:0] a, input logic we, input logic [31:0] d);
    wb_m2s_t r;
    r.adr = a;
    r.dat = d;
    r.sel = 4'hF;
    r.we  = we;
    r.cyc = 1'b1;
    r.stb = 1'b1;
    return r;
  endfunction

  // live keeps rx_ready low for the first cycle out of reset
  assign rx_ready_o = live && (state inside {IDLE, ADDR, WR_DATA, WR_DRAIN, RD_DRAIN});
  assign rx_fire    = rx_valid_i & rx_ready_o;
  assign tx_fire    = tx_valid_o & tx_ready_i;
  assign wb_fail    = wb_m2s_o.cyc & (wb_s2m_i.err | tmo_hit);
  assign wb_ok      = wb_m2s_o.cyc & wb_s2m_i.ack & ~wb_fail;
  assign busy_o     = (state != IDLE);
  assign tx_dst_o   = 8'(CHANNEL_ID);

`ifdef USB_WB_BRIDGE_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)           tmo_cnt <= '0;
    else if (!wb_m2s_o.cyc) tmo_cnt <= '0;
    else                   tmo_cnt <= tmo_cnt + 1'b1;
  end

  assign tmo_hit = wb_m2s_o.cyc && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      live        <= 1'b0;
      op          <= '0;
      n           <= '0;
      cnt         <= '0;
      done        <= '0;
      addr        <= '0;
      last_seen   <= 1'b0;
      malformed   <= 1'b0;
      wberr       <= 1'b0;
      tmo         <= 1'b0;
      tx_valid_o  <= 1'b0;
      tx_last_o   <= 1'b0;
      tx_data_o   <= '0;
      tx_length_o <= '0;
      wb_m2s_o    <= '0;
    end else begin
      live <= 1'b1;
      if (wb_ok || wb_fail) wb_m2s_o <= '0;
      if (wb_fail) begin
        wberr <= 1'b1;
        tmo   <= tmo | tmo_hit;
      end
      if (wb_ok) begin
        done <= done + 8'd1;
        addr <= addr + 32'd4;
      end
      case (state)
        IDLE: if (rx_fire) begin
          op        <= rx_data_i[31:28];
          n         <= rx_data_i[7:0];
          cnt       <= '0;
          done      <= '0;
          malformed <= 1'b0;
          wberr     <= 1'b0;
          tmo       <= 1'b0;
          last_seen <= 1'b0;
          if (rx_last_i) begin
            malformed   <= 1'b1;
            tx_length_o <= 32'd4;
            state       <= STATUS;
          end else begin
            state <= ADDR;
          end
        end
        ADDR: if (rx_fire) begin
          addr        <= {rx_data_i[31:2], 2'b00};
          tx_length_o <= 32'd4;
          if (!(op == 4'd1 || op == 4'd2) || n == 8'd0) begin
            malformed <= 1'b1;
            state     <= rx_last_i ? STATUS : WR_DRAIN;
          end else if (op == 4'd1) begin
            if (rx_last_i) begin
              malformed <= 1'b1;
              state     <= STATUS;
            end else begin
              state <= WR_DATA;
            end
          end else begin
            tx_length_o <= {22'd0, n, 2'b00} + 32'd4;
            if (rx_last_i) begin
              wb_m2s_o <= wb_req({rx_data_i[31:2], 2'b00}, 1'b0, 32'd0);
              state    <= RD_WB;
            end else begin
              state <= RD_DRAIN;
            end
          end
        end
        WR_DATA: if (rx_fire) begin
          cnt       <= cnt + 8'd1;
          last_seen <= rx_last_i;
          wb_m2s_o  <= wb_req(addr, 1'b1, rx_data_i);
          state     <= WB_WR;
        end
        WB_WR: if (wb_ok || wb_fail) begin
          if (cnt == n) begin
            state <= last_seen ? STATUS : WR_DRAIN;
          end else if (last_seen) begin
            malformed <= 1'b1;
            state     <= STATUS;
          end else begin
            state <= wb_fail ? WR_DRAIN : WR_DATA;
          end
        end
        // Drains unused write data after an error, surplus words and bad-op payloads
        WR_DRAIN: if (rx_fire) begin
          if (cnt >= n) malformed <= 1'b1;
          else          cnt <= cnt + 8'd1;
          if (rx_last_i) begin
            if ({1'b0, cnt} + 9'd1 < {1'b0, n}) malformed <= 1'b1;
            state <= STATUS;
          end
        end
        RD_DRAIN: if (rx_fire) begin
          malformed <= 1'b1;
          if (rx_last_i) begin
            wb_m2s_o <= wb_req(addr, 1'b0, 32'd0);
            state    <= RD_WB;
          end
        end
        RD_WB: if (wb_ok || wb_fail) begin
          tx_data_o  <= wb_ok ? wb_s2m_i.dat : 32'd0;
          tx_valid_o <= 1'b1;
          state      <= RD_TX;
        end
        RD_TX: if (tx_fire) begin
          cnt <= cnt + 8'd1;
          if (cnt + 8'd1 == n) begin
            tx_valid_o <= 1'b0;
            state      <= STATUS;
          end else if (wberr) begin
            tx_data_o <= 32'd0;
          end else begin
            tx_valid_o <= 1'b0;
            wb_m2s_o   <= wb_req(addr, 1'b0, 32'd0);
            state      <= RD_WB;
          end
        end
        STATUS: begin
          if (!tx_valid_o) begin
            tx_data_o  <= {op, 9'd0, tmo, malformed, wberr, 8'd0, done};
            tx_valid_o <= 1'b1;
            tx_last_o  <= 1'b1;
          end else if (tx_ready_i) begin
            tx_valid_o <= 1'b0;
            tx_last_o  <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_usb_wb_bridge.sv
// tb/tb_usb_wb_bridge.sv - randomized self-checking bench for usb_wb_bridge
`timescale 1ns/1ps
module tb_usb_wb_bridge;
  import usb_wb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_valid = 1'b0, rx_last = 1'b0, tx_ready = 1'b0;
  logic [31:0] rx_data = '0;
  logic        rx_ready_o, tx_valid_o, tx_last_o, busy_o;
  logic [31:0] tx_data_o, tx_length_o;
  logic [7:0]  tx_dst_o;
  wb_m2s_t     wb_m2s_o;
  wb_s2m_t     s2m = '0;

  always #5 clk = ~clk;

  usb_wb_bridge #(.CHANNEL_ID(1), .TIMEOUT_CYCLES(1024)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .rx_valid_i(rx_valid), .rx_ready_o(rx_ready_o), .rx_data_i(rx_data), .rx_last_i(rx_last),
    .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready), .tx_data_o(tx_data_o), .tx_dst_o(tx_dst_o),
    .tx_length_o(tx_length_o), .tx_last_o(tx_last_o),
    .wb_m2s_o(wb_m2s_o), .wb_s2m_i(s2m), .busy_o(busy_o)
  );

  int total = 0, bad = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rd_val(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3C3_1234;
  endfunction

  typedef struct { logic we; logic [31:0] adr; logic [31:0] dat; } acc_t;

  // Wishbone slave: random latency, error injection on a chosen access, optional hang
  acc_t acc_q[$];
  int   err_at = -1, acc_idx = 0, lat = 0, wcnt = 0, max_lat = 2;
  bit   hang = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      s2m  = '0;
      wcnt = 0;
    end else if (s2m.ack || s2m.err) begin
      s2m  = '0;
      wcnt = 0;
      lat  = $urandom_range(max_lat, 0);
      check("wb_gap", wb_m2s_o.cyc, 1'b0);
    end else if (wb_m2s_o.cyc && wb_m2s_o.stb && !hang) begin
      if (wcnt >= lat) begin
        check("wb_sel", wb_m2s_o.sel, 4'hF);
        acc_q.push_back('{wb_m2s_o.we, wb_m2s_o.adr, wb_m2s_o.dat});
        if (acc_idx == err_at) begin
          s2m.err = 1'b1;
        end else begin
          s2m.ack = 1'b1;
          s2m.dat = wb_m2s_o.we ? 32'hDEAD_BEEF : rd_val(wb_m2s_o.adr);
        end
        acc_idx++;
      end else begin
        wcnt++;
      end
    end
  end

  // TX sink: ready pattern per mode (0 random, 1 toggle, 2 always) and hold-while-stalled checks
  logic [31:0] txw_q[$], txlen_q[$];
  logic        txl_q[$];
  int          rdy_mode = 0;
  bit          stall = 1'b0;
  logic [31:0] pd;
  logic        pl;

  always @(negedge clk) begin
    if (!rst_n) begin
      tx_ready = 1'b0;
      stall    = 1'b0;
    end else begin
      if (stall) begin
        check("tx_hold_valid", tx_valid_o, 1'b1);
        check("tx_hold_data", {tx_data_o, tx_last_o}, {pd, pl});
      end
      case (rdy_mode)
        0:       tx_ready = 1'($urandom_range(1, 0));
        1:       tx_ready = ~tx_ready;
        default: tx_ready = 1'b1;
      endcase
      if (tx_valid_o && tx_ready) begin
        txw_q.push_back(tx_data_o);
        txl_q.push_back(tx_last_o);
        txlen_q.push_back(tx_length_o);
      end
      stall = tx_valid_o && !tx_ready;
      pd    = tx_data_o;
      pl    = tx_last_o;
    end
  end

  task automatic send(input logic [31:0] w[$]);
    int guard;
    for (int i = 0; i < w.size(); i++) begin
      if ($urandom_range(3, 0) == 0) begin
        rx_valid = 1'b0;
        rx_data  = $urandom;
        @(negedge clk);
      end
      rx_valid = 1'b1;
      rx_data  = w[i];
      rx_last  = (i == w.size() - 1);
      guard    = 0;
      while (!rx_ready_o && guard < 200) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 200) check("rx_accept", rx_ready_o, 1'b1);
      @(negedge clk);
    end
    rx_valid = 1'b0;
    rx_last  = 1'b0;
  endtask

  task automatic run_txn(input logic [3:0] op, input logic [7:0] n, input logic [31:0] a,
                         input int plen, input int e_at, input int rmode, input logic [31:0] d0);
    logic [31:0] pkt[$], exp_tx[$], exp_len, ad;
    acc_t        exp_acc[$];
    bit          malf, werr;
    int          done, avail, k, guard;

    pkt.push_back({op, 20'd0, n});
    if (plen > 1) pkt.push_back(a);
    for (int i = 2; i < plen; i++) pkt.push_back(d0 + 32'(i - 2));

    malf = 1'b0; werr = 1'b0; done = 0; exp_len = 32'd4;
    if (plen == 1) begin
      malf = 1'b1;
    end else if (!(op == 4'd1 || op == 4'd2) || n == 8'd0) begin
      malf = 1'b1;
    end else if (op == 4'd2) begin
      exp_len = 32'd4 * (32'(n) + 32'd1);
      if (plen > 2) malf = 1'b1;
      for (int i = 0; i < n; i++) begin
        ad = (a & ~32'h3) + 32'(4 * i);
        if (werr) begin
          exp_tx.push_back(32'd0);
        end else begin
          exp_acc.push_back('{1'b0, ad, 32'd0});
          if (i == e_at) begin
            werr = 1'b1;
            exp_tx.push_back(32'd0);
          end else begin
            done++;
            exp_tx.push_back(rd_val(ad));
          end
        end
      end
    end else begin
      avail = plen - 2;
      k     = (avail < n) ? avail : n;
      if (avail != n) malf = 1'b1;
      for (int i = 0; i < k && !werr; i++) begin
        ad = (a & ~32'h3) + 32'(4 * i);
        exp_acc.push_back('{1'b1, ad, pkt[2 + i]});
        if (i == e_at) werr = 1'b1;
        else           done++;
      end
    end
    exp_tx.push_back({op, 9'd0, 1'b0, malf, werr, 8'd0, 8'(done)});

    acc_q.delete(); txw_q.delete(); txl_q.delete(); txlen_q.delete();
    acc_idx  = 0;
    err_at   = e_at;
    rdy_mode = rmode;
    @(negedge clk);
    send(pkt);
    guard = 0;
    while (!(txl_q.size() > 0 && txl_q[txl_q.size() - 1] === 1'b1) && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 3000) check("tx_end_seen", txl_q.size(), exp_tx.size());
    repeat (2) @(negedge clk);

    check("busy_idle", busy_o, 1'b0);
    check("wb_count", acc_q.size(), exp_acc.size());
    for (int i = 0; i < acc_q.size() && i < exp_acc.size(); i++) begin
      check("wb_we", acc_q[i].we, exp_acc[i].we);
      check("wb_adr", acc_q[i].adr, exp_acc[i].adr);
      if (exp_acc[i].we) check("wb_wdat", acc_q[i].dat, exp_acc[i].dat);
    end
    check("tx_count", txw_q.size(), exp_tx.size());
    for (int i = 0; i < txw_q.size() && i < exp_tx.size(); i++) begin
      check("tx_data", txw_q[i], exp_tx[i]);
      check("tx_last", txl_q[i], (i == exp_tx.size() - 1));
      check("tx_length", txlen_q[i], exp_len);
    end
  endtask

  logic [3:0] ops[10] = '{4'd1, 4'd2, 4'd1, 4'd2, 4'd1, 4'd2, 4'd0, 4'd3, 4'd7, 4'd15};

  initial begin
    int         guard, plen, e_at;
    logic [3:0] op;
    logic [7:0] n;

    repeat (3) @(negedge clk);
    check("rst_rx_ready", rx_ready_o, 1'b0);
    check("rst_tx_valid", tx_valid_o, 1'b0);
    check("rst_tx_last", tx_last_o, 1'b0);
    check("rst_tx_data", tx_data_o, 32'd0);
    check("rst_tx_length", tx_length_o, 32'd0);
    check("rst_wb", wb_m2s_o, '0);
    check("rst_busy", busy_o, 1'b0);
    check("tx_dst", tx_dst_o, 8'd1);
    rst_n = 1'b1;

    max_lat = 0;
    run_txn(4'd1, 8'd2, 32'h0000_1000, 4, -1, 2, 32'hA5A5_0001);
    max_lat = 2;
    run_txn(4'd2, 8'd3, 32'h0000_2000, 2, -1, 1, 32'd0);
    run_txn(4'd2, 8'd3, 32'h0000_2000, 2, 1, 0, 32'd0);
    run_txn(4'd1, 8'd4, 32'h0000_3000, 4, -1, 0, 32'h1234_0000);
    run_txn(4'd7, 8'd1, 32'h0000_4000, 5, -1, 0, 32'h5555_0000);
    run_txn(4'd2, 8'd3, 32'hFFFF_FFFB, 2, -1, 0, 32'd0);
    run_txn(4'd1, 8'd0, 32'h0000_5000, 3, -1, 2, 32'h0);
    run_txn(4'd2, 8'd2, 32'h0000_6000, 1, -1, 2, 32'h0);
    run_txn(4'd1, 8'd3, 32'h0000_7000, 2, -1, 2, 32'h0);

    for (int t = 0; t < 40; t++) begin
      op = ops[$urandom_range(9, 0)];
      n  = 8'($urandom_range(6, 0));
      if (op == 4'd1) plen = ($urandom_range(3, 0) == 0) ? $urandom_range(n + 4, 1) : n + 2;
      else            plen = ($urandom_range(3, 0) == 0) ? $urandom_range(4, 1) : 2;
      e_at = ($urandom_range(3, 0) == 0 && n != 0) ? $urandom_range(n - 1, 0) : -1;
      run_txn(op, n, $urandom, plen, e_at, $urandom_range(2, 0), $urandom);
    end

    // Reset in the middle of a stalled Wishbone write
    hang     = 1'b1;
    rdy_mode = 2;
    acc_q.delete();
    @(negedge clk);
    send('{32'h1000_0001, 32'h0000_8000, 32'hCAFE_F00D});
    guard = 0;
    while (!wb_m2s_o.cyc && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("rst_mid_cyc_pre", wb_m2s_o.cyc, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_wb", wb_m2s_o, '0);
    check("rst_mid_busy", busy_o, 1'b0);
    check("rst_mid_tx_valid", tx_valid_o, 1'b0);
    @(negedge clk);
    hang  = 1'b0;
    rst_n = 1'b1;
    run_txn(4'd2, 8'd2, 32'h0000_9000, 2, -1, 0, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
